// File: rtl/button_pkg.sv
// Shared constants, state encoding and helpers for the push-button
// debounce / gesture decoder.
package button_pkg;

  // Reference clock of the front-panel domain.
  localparam int unsigned CLK_HZ = 27_000_000;

  // Default timings: 10 ms debounce, 1 s long press, 200 ms repeat.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int unsigned DEF_LONG_CYCLES     = CLK_HZ;
  localparam int unsigned DEF_REPEAT_CYCLES   = CLK_HZ / 5;

  // Gesture FSM encoding.
  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_PRESS_DEB = 3'd1;
  localparam logic [2:0] ENC_HELD      = 3'd2;
  localparam logic [2:0] ENC_LONG_HELD = 3'd3;
  localparam logic [2:0] ENC_REL_DEB   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_PRESS_DEB = ENC_PRESS_DEB,
    ST_HELD      = ENC_HELD,
    ST_LONG_HELD = ENC_LONG_HELD,
    ST_REL_DEB   = ENC_REL_DEB
  } btn_state_t;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int unsigned max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/event_timer.sv
// Loadable saturating up-counter with an equality compare output.
// Used for the debounce, hold and repeat timing of button_event.
module event_timer
  import button_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int          W   = cnt_width(MAX)
) (
  input  logic         clk_dst,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] cmp_val,
  output logic         hit
);

  localparam logic [W-1:0] SAT = W'(MAX);

  logic [W-1:0] count;

  // Load has priority over counting; counting stops at MAX instead of wrapping.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != SAT)) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == cmp_val);

endmodule

// File: rtl/button_event.sv
// Debounce and gesture decoder for a synchronised front-panel button.
// Produces a debounced level plus one-cycle press, release, long-press
// and auto-repeat events.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk_dst,
  input  logic rst_n,
  input  logic level_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int          DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int          HOLD_W  = cnt_width(LONG_CYCLES);
  localparam bit          REP_ON  = (REPEAT_CYCLES != 0);
  localparam int unsigned REP_MAX = REP_ON ? REPEAT_CYCLES : 1;
  localparam int          REP_W   = cnt_width(REP_MAX);

  // Debounce compares against the full count; hold and repeat compare one
  // below their period so the event lands on the edge that completes it.
  localparam logic [DEB_W-1:0]  DEB_CMP   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_CMP  = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = '0;
  localparam logic [REP_W-1:0]  REP_CMP   = REP_W'(REP_MAX - 1);
  localparam logic [REP_W-1:0]  REP_ZERO  = '0;

  btn_state_t state;
  logic       ret_long;
  logic       raw;

  logic deb_load, deb_en, deb_hit;
  logic hold_load, hold_en, hold_hit;
  logic rep_load, rep_en, rep_hit;

  assign raw = level_in ^ ACTIVE_LOW;

  // Timer controls derived from the current state and the raw level.
  always_comb begin
    deb_load  = 1'b0;
    deb_en    = 1'b0;
    hold_load = 1'b0;
    hold_en   = 1'b0;
    rep_load  = 1'b0;
    rep_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (raw) deb_load = 1'b1;
      end
      ST_PRESS_DEB: begin
        if (raw) begin
          if (deb_hit) hold_load = 1'b1;
          else         deb_en    = 1'b1;
        end
      end
      ST_HELD: begin
        if (!raw) begin
          deb_load = 1'b1;
        end else begin
          hold_en = 1'b1;
          if (hold_hit) rep_load = 1'b1;
        end
      end
      ST_LONG_HELD: begin
        if (!raw) begin
          deb_load = 1'b1;
        end else if (REP_ON) begin
          if (rep_hit) rep_load = 1'b1;
          else         rep_en   = 1'b1;
        end
      end
      ST_REL_DEB: begin
        if (!raw && !deb_hit) deb_en = 1'b1;
      end
      default: ;
    endcase
  end

  event_timer #(.MAX(DEBOUNCE_CYCLES), .W(DEB_W)) u_deb_timer (
    .clk_dst  (clk_dst),
    .rst_n    (rst_n),
    .load     (deb_load),
    .load_val (DEB_ONE),
    .en       (deb_en),
    .cmp_val  (DEB_CMP),
    .hit      (deb_hit)
  );

  event_timer #(.MAX(LONG_CYCLES), .W(HOLD_W)) u_hold_timer (
    .clk_dst  (clk_dst),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_val (HOLD_ZERO),
    .en       (hold_en),
    .cmp_val  (HOLD_CMP),
    .hit      (hold_hit)
  );

  event_timer #(.MAX(REP_MAX), .W(REP_W)) u_rep_timer (
    .clk_dst  (clk_dst),
    .rst_n    (rst_n),
    .load     (rep_load),
    .load_val (REP_ZERO),
    .en       (rep_en),
    .cmp_val  (REP_CMP),
    .hit      (rep_hit)
  );

  // Gesture FSM with registered level and single-cycle event outputs.
  always_ff @(posedge clk_dst or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ret_long      <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (raw) state <= ST_PRESS_DEB;
        end
        ST_PRESS_DEB: begin
          if (!raw) begin
            state <= ST_IDLE;
          end else if (deb_hit) begin
            state       <= ST_HELD;
            press_pulse <= 1'b1;
            pressed     <= 1'b1;
          end
        end
        ST_HELD: begin
          if (!raw) begin
            state    <= ST_REL_DEB;
            ret_long <= 1'b0;
          end else if (hold_hit) begin
            state      <= ST_LONG_HELD;
            long_pulse <= 1'b1;
          end
        end
        ST_LONG_HELD: begin
          if (!raw) begin
            state    <= ST_REL_DEB;
            ret_long <= 1'b1;
          end else if (REP_ON && rep_hit) begin
            repeat_pulse <= 1'b1;
          end
        end
        ST_REL_DEB: begin
          if (raw) begin
            state <= ret_long ? ST_LONG_HELD : ST_HELD;
          end else if (deb_hit) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
            pressed       <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event: two instances (repeat enabled / disabled) share
// one stimulus and are compared every cycle against a run-length and
// hold-credit reference model.
module tb_button_event;

  localparam int unsigned D = 4;
  localparam int unsigned L = 20;
  localparam int unsigned R0 = 5;
  localparam int unsigned R1 = 0;

  logic clk_dst = 1'b0;
  logic rst_n   = 1'b0;
  logic level_in = 1'b1;

  logic [1:0] pressed_o, press_o, release_o, long_o, repeat_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  int unsigned rep_cfg [2] = '{R0, R1};
  int          run_len;
  logic        prev_raw;
  logic        m_pressed   [2];
  int          hold_credit [2];
  logic        long_done   [2];
  int          rep_credit  [2];
  logic        e_press [2], e_release [2], e_long [2], e_repeat [2];

  button_event #(
    .DEBOUNCE_CYCLES (D), .LONG_CYCLES (L), .REPEAT_CYCLES (R0), .ACTIVE_LOW (1'b1)
  ) dut0 (
    .clk_dst (clk_dst), .rst_n (rst_n), .level_in (level_in),
    .pressed (pressed_o[0]), .press_pulse (press_o[0]), .release_pulse (release_o[0]),
    .long_pulse (long_o[0]), .repeat_pulse (repeat_o[0])
  );

  button_event #(
    .DEBOUNCE_CYCLES (D), .LONG_CYCLES (L), .REPEAT_CYCLES (R1), .ACTIVE_LOW (1'b1)
  ) dut1 (
    .clk_dst (clk_dst), .rst_n (rst_n), .level_in (level_in),
    .pressed (pressed_o[1]), .press_pulse (press_o[1]), .release_pulse (release_o[1]),
    .long_pulse (long_o[1]), .repeat_pulse (repeat_o[1])
  );

  // Free-running destination clock.
  always #5 clk_dst = ~clk_dst;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    run_len  = 0;
    prev_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_pressed[i]   = 1'b0;
      hold_credit[i] = 0;
      long_done[i]   = 1'b0;
      rep_credit[i]  = 0;
      e_press[i]     = 1'b0;
      e_release[i]   = 1'b0;
      e_long[i]      = 1'b0;
      e_repeat[i]    = 1'b0;
    end
  endtask

  // A change is accepted once the raw level has been steady for D+1
  // consecutive samples. Hold time accrues only on samples where the
  // button is accepted as pressed and both this and the previous raw
  // sample are pressed, so bounce samples and the bounce return are lost.
  task automatic modelStep(input logic raw);
    logic counting;
    if (raw == prev_raw) run_len++;
    else                 run_len = 1;
    for (int i = 0; i < 2; i++) begin
      e_press[i]   = 1'b0;
      e_release[i] = 1'b0;
      e_long[i]    = 1'b0;
      e_repeat[i]  = 1'b0;
      counting = m_pressed[i] && raw && prev_raw;
      if (!m_pressed[i] && raw && run_len == int'(D) + 1) begin
        e_press[i]     = 1'b1;
        m_pressed[i]   = 1'b1;
        hold_credit[i] = 0;
        long_done[i]   = 1'b0;
        rep_credit[i]  = 0;
      end else if (m_pressed[i] && !raw && run_len == int'(D) + 1) begin
        e_release[i] = 1'b1;
        m_pressed[i] = 1'b0;
      end else if (counting) begin
        if (!long_done[i]) begin
          hold_credit[i]++;
          if (hold_credit[i] == int'(L)) begin
            e_long[i]     = 1'b1;
            long_done[i]  = 1'b1;
            rep_credit[i] = 0;
          end
        end else if (rep_cfg[i] != 0) begin
          rep_credit[i]++;
          if (rep_credit[i] == int'(rep_cfg[i])) begin
            e_repeat[i]   = 1'b1;
            rep_credit[i] = 0;
          end
        end
      end
    end
    prev_raw = raw;
  endtask

  task automatic checkAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("dut%0d.pressed", i),       pressed_o[i], m_pressed[i]);
      checkOutput($sformatf("dut%0d.press_pulse", i),   press_o[i],   e_press[i]);
      checkOutput($sformatf("dut%0d.release_pulse", i), release_o[i], e_release[i]);
      checkOutput($sformatf("dut%0d.long_pulse", i),    long_o[i],    e_long[i]);
      checkOutput($sformatf("dut%0d.repeat_pulse", i),  repeat_o[i],  e_repeat[i]);
    end
  endtask

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s.dut%0d.pressed", tag, i),       pressed_o[i], 1'b0);
      checkOutput($sformatf("%s.dut%0d.press_pulse", tag, i),   press_o[i],   1'b0);
      checkOutput($sformatf("%s.dut%0d.release_pulse", tag, i), release_o[i], 1'b0);
      checkOutput($sformatf("%s.dut%0d.long_pulse", tag, i),    long_o[i],    1'b0);
      checkOutput($sformatf("%s.dut%0d.repeat_pulse", tag, i),  repeat_o[i],  1'b0);
    end
  endtask

  // Drive a level for n cycles; sample model and DUT 1 ns after each edge.
  task automatic applyStimulus(input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      level_in = lvl;
      @(posedge clk_dst);
      cyc++;
      modelStep(~level_in);
      #1;
      checkAll();
    end
  endtask

  initial begin
    logic lvl;
    int   len;

    $display("[TB] start");
    modelReset();
    rst_n    = 1'b0;
    level_in = 1'b1;
    repeat (3) @(posedge clk_dst);
    #1;
    checkAllZero("reset");
    #3 rst_n = 1'b1;

    applyStimulus(1'b1, 3);

    $display("[TB] glitch rejection");
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 6);

    $display("[TB] clean press and release");
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 8);

    $display("[TB] long press with repeat");
    applyStimulus(1'b0, 45);

    $display("[TB] release bounce while long-held");
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 20);
    applyStimulus(1'b1, 8);

    $display("[TB] long hold of 60 cycles");
    applyStimulus(1'b0, 65);
    applyStimulus(1'b1, 8);

    $display("[TB] asynchronous reset while held");
    applyStimulus(1'b0, 10);
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    modelReset();
    level_in = 1'b1;
    repeat (2) @(posedge clk_dst);
    #1;
    checkAllZero("in_reset");
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 6);

    $display("[TB] randomized bursts");
    for (int s = 0; s < 40; s++) begin
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(20, 45));
      else                           len = int'($urandom_range(1, 7));
      applyStimulus(lvl, len);
    end
    applyStimulus(1'b1, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
